qpu_lsu_icb_dmem: RTL and testbench



---
 rtl/qpu_lsu_pkg.sv | 11 +
 rtl/qpu_icb_rsp_fifo.sv | 43 ++++
 rtl/qpu_lsu_icb_dmem.sv | 55 +++++
 tb/tb_qpu_lsu_icb_dmem.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/qpu_lsu_pkg.sv
// qpu_lsu_pkg: shared widths, memory depth and response-entry layout for the LSU ICB path
package qpu_lsu_pkg;
    localparam int QPU_ADDR_SIZE = 32;
    localparam int QPU_XLEN = 32;
    localparam int DMEM_DEPTH = 1024;
    localparam int ICB_RSP_DEPTH = 2;
    typedef struct packed {
        logic [QPU_XLEN-1:0] rdata;
        logic                err;
    } icb_rsp_t;
endpackage

// File: rtl/qpu_icb_rsp_fifo.sv
// qpu_icb_rsp_fifo: generic synchronous FIFO; full/empty come from count, pointers wrap modulo DEPTH
module qpu_icb_rsp_fifo #(
    parameter int W = 33,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  entries [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          do_push, do_pop;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = entries[rptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= inc(wptr);
            if (do_pop) rptr <= inc(rptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !rst) entries[wptr] <= din;
    end
endmodule

// File: rtl/qpu_lsu_icb_dmem.sv
// qpu_lsu_icb_dmem: word-addressed data memory behind the LSU ICB with byte-masked stores
// and an in-order 2-entry response buffer so the LSU can keep issuing under rsp back-pressure.
module qpu_lsu_icb_dmem
    import qpu_lsu_pkg::*;
#(
    parameter int AW = QPU_ADDR_SIZE,
    parameter int XLEN = QPU_XLEN,
    parameter int DEPTH = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_icb_cmd_valid,
    output logic              lsu_icb_cmd_ready,
    input  logic [AW-1:0]     lsu_icb_cmd_addr,
    input  logic              lsu_icb_cmd_read,
    input  logic [XLEN-1:0]   lsu_icb_cmd_wdata,
    input  logic [XLEN/8-1:0] lsu_icb_cmd_wmask,
    output logic              lsu_icb_rsp_valid,
    input  logic              lsu_icb_rsp_ready,
    output logic [XLEN-1:0]   lsu_icb_rsp_rdata,
    output logic              lsu_icb_rsp_err
);
    localparam int MW = XLEN / 8;
    localparam int LW = $clog2(DEPTH);
    localparam logic [AW:0] LIM = (AW + 1)'(DEPTH * 4);
    logic [XLEN-1:0] mem [DEPTH];
    logic [LW-1:0]   widx;
    logic            err, accept, wr_en, full, empty;
    logic [XLEN:0]   rsp_in, rsp_head;
    assign widx   = lsu_icb_cmd_addr[LW+1:2];
    assign err    = (lsu_icb_cmd_addr[1:0] != 2'b00) || ({1'b0, lsu_icb_cmd_addr} >= LIM);
    assign accept = lsu_icb_cmd_valid && lsu_icb_cmd_ready;
    // reset wins over a store accepted on the same edge
    assign wr_en  = accept && !lsu_icb_cmd_read && !err && !rst;
    assign rsp_in = {(lsu_icb_cmd_read && !err) ? mem[widx] : '0, err};
    always_ff @(posedge clk) begin
        if (wr_en)
            for (int i = 0; i < MW; i++)
                if (lsu_icb_cmd_wmask[i]) mem[widx][8*i +: 8] <= lsu_icb_cmd_wdata[8*i +: 8];
    end
    qpu_icb_rsp_fifo #(.W(XLEN + 1), .DEPTH(ICB_RSP_DEPTH)) u_rsp_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (accept),
        .din  (rsp_in),
        .pop  (lsu_icb_rsp_valid && lsu_icb_rsp_ready),
        .full (full),
        .empty(empty),
        .head (rsp_head)
    );
    assign lsu_icb_cmd_ready = !full;
    assign lsu_icb_rsp_valid = !empty;
    assign lsu_icb_rsp_rdata = empty ? '0 : rsp_head[XLEN:1];
    assign lsu_icb_rsp_err   = !empty && rsp_head[0];
endmodule

// File: tb/tb_qpu_lsu_icb_dmem.sv
// tb_qpu_lsu_icb_dmem: random and directed traffic against a queue-based model of the memory and response stream
module tb_qpu_lsu_icb_dmem;
    logic        clk = 0;
    logic        rst, cmd_valid, cmd_ready, cmd_read, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] cmd_addr, cmd_wdata, rsp_rdata;
    logic [3:0]  cmd_wmask;
    int          checks = 0, errors = 0;
    bit          started = 0;
    logic [31:0] mdl [0:1023];
    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;
    exp_t q[$];

    qpu_lsu_icb_dmem dut (
        .clk              (clk),
        .rst              (rst),
        .lsu_icb_cmd_valid(cmd_valid),
        .lsu_icb_cmd_ready(cmd_ready),
        .lsu_icb_cmd_addr (cmd_addr),
        .lsu_icb_cmd_read (cmd_read),
        .lsu_icb_cmd_wdata(cmd_wdata),
        .lsu_icb_cmd_wmask(cmd_wmask),
        .lsu_icb_rsp_valid(rsp_valid),
        .lsu_icb_rsp_ready(rsp_ready),
        .lsu_icb_rsp_rdata(rsp_rdata),
        .lsu_icb_rsp_err  (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", n, got, want, $time);
        end
    endtask

    // Model: buffer occupancy is the queue length, memory is a plain word array
    always @(posedge clk) begin
        exp_t e;
        bit   pop, acc, bad;
        if (rst) begin
            q.delete();
            started = 1;
        end else if (started) begin
            pop = q.size() != 0 && rsp_ready;
            acc = cmd_valid && q.size() != 2;
            bad = cmd_addr[1:0] != 0 || cmd_addr >= 32'd4096;
            e.d = 0;
            e.e = bad;
            if (acc && !bad) begin
                if (cmd_read) e.d = mdl[cmd_addr[11:2]];
                else for (int i = 0; i < 4; i++)
                    if (cmd_wmask[i]) mdl[cmd_addr[11:2]][8*i +: 8] = cmd_wdata[8*i +: 8];
            end
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, q.size() != 2});
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, q.size() != 0});
            if (q.size() != 0) begin
                chk("rsp_rdata", rsp_rdata, q[0].d);
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, q[0].e});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit v, input bit rd, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        cmd_valid = v;
        cmd_read  = rd;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wmask = m;
    endtask

    task automatic lit(input string n, input logic v, input logic [31:0] d, input logic e);
        chk({n, "_valid"}, {31'b0, rsp_valid}, {31'b0, v});
        chk({n, "_rdata"}, rsp_rdata, d);
        chk({n, "_err"}, {31'b0, rsp_err}, {31'b0, e});
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        rst = 1;
        rsp_ready = 1;
        drive(0, 0, 0, 0, 0);
        step();
        step();
        rst = 0;
        lit("reset", 0, 0, 0);
        chk("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        for (int w = 0; w < 32; w++) begin
            drive(1, 0, w * 4, $urandom, 4'hf);
            step();
        end
        drive(1, 0, 32'h0, 32'hA5A5A5A5, 4'hf);
        step();
        drive(1, 0, 32'h14, 32'hCAFEF00D, 4'hf);
        step();
        drive(1, 0, 32'h18, 32'h0BADBEEF, 4'hf);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        // masked write and readback
        drive(1, 0, 32'h10, 32'hDEADBEEF, 4'hf);
        step();
        lit("store1", 1, 0, 0);
        drive(1, 0, 32'h10, 32'h00000055, 4'h1);
        step();
        drive(1, 1, 32'h10, 0, 0);
        step();
        lit("masked_load", 1, 32'hDEADBE55, 0);
        drive(0, 0, 0, 0, 0);
        step();
        // back-pressure
        rsp_ready = 0;
        drive(1, 1, 32'h10, 0, 0);
        step();
        drive(1, 1, 32'h14, 0, 0);
        step();
        chk("bp_full_ready", {31'b0, cmd_ready}, 32'd0);
        drive(1, 1, 32'h18, 0, 0);
        step();
        chk("bp_hold_ready", {31'b0, cmd_ready}, 32'd0);
        lit("bp_hold", 1, 32'hDEADBE55, 0);
        rsp_ready = 1;
        step();
        chk("bp_after_pop_ready", {31'b0, cmd_ready}, 32'd1);
        lit("bp_second", 1, 32'hCAFEF00D, 0);
        step();
        lit("bp_third", 1, 32'h0BADBEEF, 0);
        drive(0, 0, 0, 0, 0);
        step();
        lit("bp_drained", 0, 0, 0);
        // streaming
        drive(1, 0, 32'h20, 32'h12345678, 4'hf);
        step();
        chk("stream_ready1", {31'b0, cmd_ready}, 32'd1);
        drive(1, 1, 32'h20, 0, 0);
        step();
        chk("stream_ready2", {31'b0, cmd_ready}, 32'd1);
        lit("stream_load", 1, 32'h12345678, 0);
        // errors
        drive(1, 1, 32'h3, 0, 0);
        step();
        lit("err_misaligned", 1, 0, 1);
        drive(1, 0, 32'h1000, 32'hFFFFFFFF, 4'hf);
        step();
        lit("err_range", 1, 0, 1);
        drive(1, 1, 32'h0, 0, 0);
        step();
        lit("err_word0", 1, 32'hA5A5A5A5, 0);
        drive(0, 0, 0, 0, 0);
        step();
        // reset mid-operation
        rsp_ready = 0;
        drive(1, 1, 32'h10, 0, 0);
        step();
        drive(1, 1, 32'h14, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        rst = 1;
        step();
        rst = 0;
        lit("rst_two_pending", 0, 0, 0);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        drive(1, 1, 32'h18, 0, 0);
        step();
        drive(1, 0, 32'h10, 32'h0, 4'hf);
        rst = 1;
        step();
        rst = 0;
        drive(0, 0, 0, 0, 0);
        lit("rst_one_pending", 0, 0, 0);
        rsp_ready = 1;
        drive(1, 1, 32'h10, 0, 0);
        step();
        lit("rst_preserved", 1, 32'hDEADBE55, 0);
        // random traffic
        for (int k = 0; k < 3000; k++) begin
            r = $urandom % 10;
            a = r < 8 ? ($urandom % 32) * 4 :
                r == 8 ? ($urandom % 32) * 4 + 1 + $urandom % 3 : 32'd4096 + ($urandom % 1024) * 4;
            rst = ($urandom % 300) == 0;
            drive($urandom % 4 != 0, $urandom % 2, a, $urandom, 4'($urandom));
            rsp_ready = $urandom % 4 != 0;
            step();
        end
        rst = 0;
        rsp_ready = 1;
        drive(0, 0, 0, 0, 0);
        repeat (4) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
